edge_event_sched: RTL and testbench

//  Edge/level event scheduler for a shared toggle resource. Detects per-channel events
//  (any-change, posedge or negedge, selected per channel), queues one pending flag per channel,
//  and round-robin arbitrates them onto a single valid/ready service port.

---
 rtl/edge_sched_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/edge_event_sched.sv | 118 +++++++++++
 tb/tb_edge_event_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_sched_pkg.sv
// Shared constants, FSM state type and edge-mode decode for the edge/level event scheduler.
package edge_sched_pkg;

    localparam logic [1:0] MODE_ANY = 2'b00;
    localparam logic [1:0] MODE_POS = 2'b01;
    localparam logic [1:0] MODE_NEG = 2'b10;
    localparam logic [1:0] MODE_OFF = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    // True when the prev->cur transition is an event under the given channel mode.
    function automatic logic mode_match(input logic [1:0] mode, input logic prev, input logic cur);
        logic hit;
        hit = 1'b0;
        case (mode)
            MODE_ANY: hit = prev ^ cur;
            MODE_POS: hit = ~prev & cur;
            MODE_NEG: hit = prev & ~cur;
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping at N.
module rr_arbiter #(
    parameter  int unsigned N     = 3,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    // Scan offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        logic [IDX_W:0] sum;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            if (req[sum[IDX_W-1:0]]) begin
                gnt_idx = sum[IDX_W-1:0];
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_event_sched.sv
// Per-channel edge/level event detection, pending/drop tracking and round-robin service of a
// shared toggle register through a single valid/ready port.
module edge_event_sched
    import edge_sched_pkg::*;
#(
    parameter  int unsigned          N_CH      = 3,
    parameter  int unsigned          CNT_W     = 8,
    parameter  logic [2*N_CH-1:0]    EDGE_MODE = 6'b10_01_00,
    localparam int unsigned          CH_W      = $clog2(N_CH)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         ev_in,
    input  logic                    clr_drop,
    output logic                    fire_valid,
    output logic [CH_W-1:0]         fire_ch,
    input  logic                    fire_ready,
    output logic                    d_out,
    output logic [N_CH-1:0]         pending,
    output logic [N_CH-1:0]         drop,
    output logic [N_CH*CNT_W-1:0]   svc_count
);

    state_t                  state, state_nxt;
    logic                    armed;
    logic [N_CH-1:0]         ev_prev;
    logic [N_CH-1:0]         det, clr_vec, pending_nxt, drop_nxt;
    logic [CH_W-1:0]         rr_ptr, rr_ptr_nxt, fire_ch_nxt, gnt_idx;
    logic                    gnt_any, accept, fire_valid_nxt, d_out_nxt;
    logic [N_CH*CNT_W-1:0]   svc_nxt;

    rr_arbiter #(.N(N_CH)) u_arb (
        .req     (pending),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign accept = (state == S_OFFER) & fire_ready;

    // Detection is gated by armed so the first post-reset sample never looks like an edge.
    always_comb begin
        det = '0;
        for (int i = 0; i < N_CH; i++) begin
            det[i] = armed & mode_match(EDGE_MODE[2*i +: 2], ev_prev[i], ev_in[i]);
        end
    end

    // A fresh event on the accepted channel re-arms it instead of counting as a drop.
    always_comb begin
        clr_vec     = '0;
        pending_nxt = '0;
        drop_nxt    = '0;
        svc_nxt     = svc_count;
        for (int i = 0; i < N_CH; i++) begin
            clr_vec[i]     = accept && (fire_ch == CH_W'(i));
            pending_nxt[i] = det[i] | (pending[i] & ~clr_vec[i]);
            drop_nxt[i]    = (det[i] & pending[i] & ~clr_vec[i]) | (drop[i] & ~clr_drop);
            if (clr_vec[i]) begin
                svc_nxt[i*CNT_W +: CNT_W] = svc_count[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt      = state;
        fire_valid_nxt = fire_valid;
        fire_ch_nxt    = fire_ch;
        rr_ptr_nxt     = rr_ptr;
        d_out_nxt      = d_out;
        case (state)
            S_IDLE: begin
                if (gnt_any) begin
                    fire_ch_nxt    = gnt_idx;
                    fire_valid_nxt = 1'b1;
                    state_nxt      = S_OFFER;
                end
            end
            S_OFFER: begin
                if (fire_ready) begin
                    d_out_nxt      = ~d_out;
                    fire_valid_nxt = 1'b0;
                    rr_ptr_nxt     = (fire_ch == CH_W'(N_CH - 1)) ? '0 : fire_ch + CH_W'(1);
                    state_nxt      = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            ev_prev    <= '0;
            rr_ptr     <= '0;
            fire_valid <= 1'b0;
            fire_ch    <= '0;
            d_out      <= 1'b0;
            pending    <= '0;
            drop       <= '0;
            svc_count  <= '0;
        end else begin
            state      <= state_nxt;
            armed      <= 1'b1;
            ev_prev    <= ev_in;
            rr_ptr     <= rr_ptr_nxt;
            fire_valid <= fire_valid_nxt;
            fire_ch    <= fire_ch_nxt;
            d_out      <= d_out_nxt;
            pending    <= pending_nxt;
            drop       <= drop_nxt;
            svc_count  <= svc_nxt;
        end
    end

endmodule

// File: tb/tb_edge_event_sched.sv
// Directed bench for edge_event_sched: ch0 any-change, ch1 posedge, ch2 negedge, 8-bit counters.
module tb_edge_event_sched;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  ev_in;
    logic        clr_drop;
    logic        fire_valid;
    logic [1:0]  fire_ch;
    logic        fire_ready;
    logic        d_out;
    logic [2:0]  pending;
    logic [2:0]  drop;
    logic [23:0] svc_count;

    int checks = 0;
    int errors = 0;

    edge_event_sched #(.N_CH(3), .CNT_W(8), .EDGE_MODE(6'b10_01_00)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ev_in      (ev_in),
        .clr_drop   (clr_drop),
        .fire_valid (fire_valid),
        .fire_ch    (fire_ch),
        .fire_ready (fire_ready),
        .d_out      (d_out),
        .pending    (pending),
        .drop       (drop),
        .svc_count  (svc_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] base);
        reset_n    = 1'b0;
        ev_in      = base;
        clr_drop   = 1'b0;
        fire_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        ev_in      = 3'b111;
        clr_drop   = 1'b0;
        fire_ready = 1'b0;
        step();
        step();
        checks++;
        if ({fire_valid, fire_ch, d_out, pending, drop, svc_count} !== 34'd0) begin
            errors++;
            $display("FAIL reset_hold got fv=%b ch=%0d d=%b pend=%b drop=%b svc=%h exp all zero",
                     fire_valid, fire_ch, d_out, pending, drop, svc_count);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({pending, fire_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_release_cyc%0d got pend=%b fv=%b exp pend=000 fv=0",
                         i, pending, fire_valid);
            end
        end
        checks++;
        if ({fire_valid, fire_ch, d_out, pending, drop, svc_count} !== 34'd0) begin
            errors++;
            $display("FAIL reset_after got fv=%b ch=%0d d=%b pend=%b drop=%b svc=%h exp all zero",
                     fire_valid, fire_ch, d_out, pending, drop, svc_count);
        end
    endtask

    task automatic test_single_posedge();
        ev_in = 3'b101;
        step();
        step();
        checks++;
        if (pending !== 3'b000) begin
            errors++;
            $display("FAIL pos_fall_ignored got pend=%b exp 000", pending);
        end
        fire_ready = 1'b1;
        ev_in = 3'b111;
        step();
        checks++;
        if ({pending, fire_valid} !== 4'b0100) begin
            errors++;
            $display("FAIL pos_pending got pend=%b fv=%b exp pend=010 fv=0", pending, fire_valid);
        end
        ev_in = 3'b101;
        step();
        checks++;
        if ({fire_valid, fire_ch} !== 3'b1_01) begin
            errors++;
            $display("FAIL pos_offer got fv=%b ch=%0d exp fv=1 ch=1", fire_valid, fire_ch);
        end
        step();
        checks++;
        if ({fire_valid, d_out, pending, svc_count} !== {1'b0, 1'b1, 3'b000, 24'h000100}) begin
            errors++;
            $display("FAIL pos_accept got fv=%b d=%b pend=%b svc=%h exp fv=0 d=1 pend=000 svc=000100",
                     fire_valid, d_out, pending, svc_count);
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({fire_valid, svc_count} !== {1'b0, 24'h000100}) begin
            errors++;
            $display("FAIL pos_single_service got fv=%b svc=%h exp fv=0 svc=000100",
                     fire_valid, svc_count);
        end
    endtask

    task automatic test_round_robin();
        do_reset(3'b100);
        fire_ready = 1'b1;
        ev_in = 3'b011;
        step();
        checks++;
        if (pending !== 3'b111) begin
            errors++;
            $display("FAIL rr_pending got %b exp 111", pending);
        end
        step();
        checks++;
        if ({fire_valid, fire_ch} !== 3'b1_00) begin
            errors++;
            $display("FAIL rr_grant0 got fv=%b ch=%0d exp fv=1 ch=0", fire_valid, fire_ch);
        end
        step();
        checks++;
        if ({fire_valid, d_out} !== 2'b01) begin
            errors++;
            $display("FAIL rr_accept0 got fv=%b d=%b exp fv=0 d=1", fire_valid, d_out);
        end
        step();
        checks++;
        if ({fire_valid, fire_ch} !== 3'b1_01) begin
            errors++;
            $display("FAIL rr_grant1 got fv=%b ch=%0d exp fv=1 ch=1", fire_valid, fire_ch);
        end
        step();
        checks++;
        if (d_out !== 1'b0) begin
            errors++;
            $display("FAIL rr_accept1 got d=%b exp 0", d_out);
        end
        step();
        checks++;
        if ({fire_valid, fire_ch} !== 3'b1_10) begin
            errors++;
            $display("FAIL rr_grant2 got fv=%b ch=%0d exp fv=1 ch=2", fire_valid, fire_ch);
        end
        step();
        checks++;
        if ({d_out, pending, svc_count} !== {1'b1, 3'b000, 24'h010101}) begin
            errors++;
            $display("FAIL rr_final got d=%b pend=%b svc=%h exp d=1 pend=000 svc=010101",
                     d_out, pending, svc_count);
        end
    endtask

    task automatic test_backpressure_drop();
        do_reset(3'b000);
        ev_in = 3'b001;
        step();
        step();
        checks++;
        if ({fire_valid, fire_ch} !== 3'b1_00) begin
            errors++;
            $display("FAIL bp_offer got fv=%b ch=%0d exp fv=1 ch=0", fire_valid, fire_ch);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 0) ev_in = 3'b000;
            if (i == 4) ev_in = 3'b001;
            step();
            checks++;
            if ({fire_valid, fire_ch} !== 3'b1_00) begin
                errors++;
                $display("FAIL bp_hold_cyc%0d got fv=%b ch=%0d exp fv=1 ch=0", i, fire_valid, fire_ch);
            end
        end
        checks++;
        if ({drop, d_out, svc_count} !== {3'b001, 1'b0, 24'h000000}) begin
            errors++;
            $display("FAIL bp_drop got drop=%b d=%b svc=%h exp drop=001 d=0 svc=000000",
                     drop, d_out, svc_count);
        end
        clr_drop = 1'b1;
        ev_in = 3'b000;
        step();
        checks++;
        if (drop !== 3'b001) begin
            errors++;
            $display("FAIL bp_clr_vs_new_drop got %b exp 001", drop);
        end
        step();
        checks++;
        if (drop !== 3'b000) begin
            errors++;
            $display("FAIL bp_clr_drop got %b exp 000", drop);
        end
        clr_drop = 1'b0;
        fire_ready = 1'b1;
        ev_in = 3'b001;
        step();
        checks++;
        if ({pending, drop, fire_valid, d_out, svc_count} !== {3'b001, 3'b000, 1'b0, 1'b1, 24'h000001}) begin
            errors++;
            $display("FAIL bp_accept_rearm got pend=%b drop=%b fv=%b d=%b svc=%h exp pend=001 drop=000 fv=0 d=1 svc=000001",
                     pending, drop, fire_valid, d_out, svc_count);
        end
        step();
        checks++;
        if ({fire_valid, fire_ch} !== 3'b1_00) begin
            errors++;
            $display("FAIL bp_reoffer got fv=%b ch=%0d exp fv=1 ch=0", fire_valid, fire_ch);
        end
        step();
        checks++;
        if ({svc_count, d_out, pending} !== {24'h000002, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL bp_second_accept got svc=%h d=%b pend=%b exp svc=000002 d=0 pend=000",
                     svc_count, d_out, pending);
        end
        fire_ready = 1'b0;
    endtask

    task automatic test_reset_mid_offer();
        do_reset(3'b000);
        fire_ready = 1'b1;
        ev_in = 3'b001;
        step();
        step();
        step();
        fire_ready = 1'b0;
        ev_in = 3'b000;
        step();
        step();
        checks++;
        if ({fire_valid, d_out, svc_count} !== {1'b1, 1'b1, 24'h000001}) begin
            errors++;
            $display("FAIL rmo_setup got fv=%b d=%b svc=%h exp fv=1 d=1 svc=000001",
                     fire_valid, d_out, svc_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({fire_valid, d_out, pending, drop, svc_count} !== 32'd0) begin
            errors++;
            $display("FAIL rmo_async got fv=%b d=%b pend=%b drop=%b svc=%h exp all zero",
                     fire_valid, d_out, pending, drop, svc_count);
        end
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_counter_wrap();
        do_reset(3'b100);
        fire_ready = 1'b1;
        ev_in = 3'b110;
        step();
        step();
        step();
        ev_in = 3'b010;
        step();
        step();
        step();
        checks++;
        if ({svc_count, d_out} !== {24'h010100, 1'b0}) begin
            errors++;
            $display("FAIL wrap_setup got svc=%h d=%b exp svc=010100 d=0", svc_count, d_out);
        end
        for (int i = 0; i < 256; i++) begin
            ev_in[0] = ~ev_in[0];
            step();
            step();
            checks++;
            if ({fire_valid, fire_ch} !== 3'b1_00) begin
                errors++;
                $display("FAIL wrap_offer_%0d got fv=%b ch=%0d exp fv=1 ch=0", i, fire_valid, fire_ch);
            end
            step();
            if (i == 254) begin
                checks++;
                if (svc_count !== 24'h0101FF) begin
                    errors++;
                    $display("FAIL wrap_255 got svc=%h exp 0101ff", svc_count);
                end
            end
        end
        checks++;
        if ({svc_count, d_out, pending} !== {24'h010100, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL wrap_final got svc=%h d=%b pend=%b exp svc=010100 d=0 pend=000",
                     svc_count, d_out, pending);
        end
    endtask

    initial begin
        test_reset();
        test_single_posedge();
        test_round_robin();
        test_backpressure_drop();
        test_reset_mid_offer();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
